// File: rtl/rc5_key_sched_ctrl_if.sv
// Table and round-key port bundle between the RC5 key-schedule controller
// (master) and the S/L register files plus the cipher core (slave).
interface rc5_key_sched_ctrl_if #(
    parameter int W   = 32,
    parameter int SAW = 5,
    parameter int LAW = 2
);
    logic [SAW-1:0] s_addr;
    logic [W-1:0]   s_wdata;
    logic           s_we;
    logic [W-1:0]   s_rdata;
    logic [LAW-1:0] l_addr;
    logic [W-1:0]   l_wdata;
    logic           l_we;
    logic [W-1:0]   l_rdata;
    logic           rk_req;
    logic [SAW-1:0] rk_index;
    logic           rk_gnt;
    logic [W-1:0]   rk_data;

    modport master (
        output s_addr, s_wdata, s_we,
        input  s_rdata,
        output l_addr, l_wdata, l_we,
        input  l_rdata,
        input  rk_req, rk_index,
        output rk_gnt, rk_data
    );

    modport slave (
        input  s_addr, s_wdata, s_we,
        output s_rdata,
        input  l_addr, l_wdata, l_we,
        output l_rdata,
        output rk_req, rk_index,
        input  rk_gnt, rk_data
    );
endinterface

// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key expansion sequencer: fills S from P/Q, runs the 3*max(T,C) mix pass
// over S and L, then lends the S-table read port to the cipher core.
module rc5_key_sched_ctrl #(
    parameter int           W = 32,
    parameter int           T = 22,
    parameter int           C = 4,
    parameter logic [W-1:0] P = 32'hB7E15163,
    parameter logic [W-1:0] Q = 32'h9E3779B9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 key_valid_o,
    rc5_key_sched_ctrl_if.master bus
);
    localparam int SAW = (T > 1) ? $clog2(T) : 1;
    localparam int LAW = (C > 1) ? $clog2(C) : 1;
    localparam int N   = 3 * ((T > C) ? T : C);
    localparam int CW  = $clog2(N + 1);
    localparam int RW  = $clog2(W);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_MIX_A = 3'd2;
    localparam logic [2:0] S_MIX_B = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [SAW-1:0] k_q, k_d;
    logic [SAW-1:0] i_q, i_d;
    logic [LAW-1:0] j_q, j_d;
    logic [CW-1:0]  n_q, n_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           kv_q, kv_d;

    logic [W-1:0]   ab, sum_a, sum_b, rot_a, rot_b;
    logic [RW-1:0]  rot_amt;
    logic [RW:0]    rot_inv;

    // A shift by the full width yields zero, so amount 0 falls out unchanged.
    always_comb begin
        ab      = a_q + b_q;
        sum_a   = bus.s_rdata + ab;
        sum_b   = bus.l_rdata + ab;
        rot_a   = {sum_a[W-4:0], sum_a[W-1:W-3]};
        rot_amt = ab[RW-1:0];
        rot_inv = (RW+1)'(W) - {1'b0, rot_amt};
        rot_b   = (sum_b << rot_amt) | (sum_b >> rot_inv);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        i_d         = i_q;
        j_d         = j_q;
        n_d         = n_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        kv_d        = kv_q;
        bus.s_addr  = bus.rk_index;
        bus.s_wdata = '0;
        bus.s_we    = 1'b0;
        bus.l_addr  = j_q;
        bus.l_wdata = '0;
        bus.l_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    k_d     = '0;
                    acc_d   = P;
                    kv_d    = 1'b0;
                end
            end
            S_INIT: begin
                bus.s_addr  = k_q;
                bus.s_wdata = acc_q;
                bus.s_we    = 1'b1;
                acc_d       = acc_q + Q;
                if (k_q == SAW'(T - 1)) begin
                    state_d = S_MIX_A;
                    i_d     = '0;
                    j_d     = '0;
                    n_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_MIX_A: begin
                bus.s_addr  = i_q;
                bus.s_wdata = rot_a;
                bus.s_we    = 1'b1;
                a_d         = rot_a;
                state_d     = S_MIX_B;
            end
            S_MIX_B: begin
                bus.l_wdata = rot_b;
                bus.l_we    = 1'b1;
                b_d         = rot_b;
                i_d         = (i_q == SAW'(T - 1)) ? '0 : i_q + 1'b1;
                j_d         = (j_q == LAW'(C - 1)) ? '0 : j_q + 1'b1;
                n_d         = n_q + 1'b1;
                if (n_q == CW'(N - 1)) begin
                    state_d = S_FIN;
                    kv_d    = 1'b1;
                end else begin
                    state_d = S_MIX_A;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= P;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            kv_q    <= kv_d;
        end
    end

    assign busy_o      = (state_q == S_INIT) || (state_q == S_MIX_A) || (state_q == S_MIX_B);
    assign done_o      = (state_q == S_FIN);
    assign key_valid_o = kv_q;
    assign bus.rk_gnt  = (state_q == S_IDLE) && bus.rk_req && kv_q;
    assign bus.rk_data = bus.s_rdata;
endmodule

// File: doc/rc5_key_sched_ctrl.md
Name: rc5_key_sched_ctrl

Overview:
- Sequences the full RC5 key expansion: S-table init from magic constants P/Q, then the 3*max(T,C) mixing pass over the S and L tables.
- Drives external S-table (T words) and L-table (C words) register files. Host preloads L before start.
- After expansion, arbitrates S-table read access to the encryption core's round-key port.
- Sits between host key loading and the rc5 encrypt/decrypt datapath.

Parameters:
- W, 32, word width; rotation amount uses low log2(W) bits.
- T, 22, S-table words (2r+2, r=10).
- C, 4, L-table words (key bytes/4).
- P, 32'hB7E15163, S init base constant.
- Q, 32'h9E3779B9, S init increment.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin expansion; sampled only in IDLE.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse at expansion completion.
- key_valid  out  1  S-table holds a completed expansion.
- s_addr  out  5  S-table address (ceil(log2 T)).
- s_wdata  out  W  S-table write data.
- s_we  out  1  S-table write enable.
- s_rdata  in  W  S-table asynchronous read data at s_addr.
- l_addr  out  2  L-table address (ceil(log2 C)).
- l_wdata  out  W  L-table write data.
- l_we  out  1  L-table write enable.
- l_rdata  in  W  L-table asynchronous read data at l_addr.
- rk_req  in  1  round-key read request from cipher core.
- rk_index  in  5  requested S index.
- rk_gnt  out  1  request granted; rk_data valid this cycle.
- rk_data  out  W  round key (= s_rdata when granted).

Behaviour:
- Reset values: busy=0, done=0, key_valid=0, s_we=0, l_we=0, rk_gnt=0. Internal A=B=0, i=j=k=0, iteration counter=0. State=IDLE.
- Reset mid-expansion aborts immediately, with no further writes. Table contents are then undefined to the core because key_valid=0.
- States: IDLE -> INIT -> MIX_A <-> MIX_B -> FIN -> IDLE.
- IDLE:
  - On start: go to INIT and clear key_valid.
  - rk_gnt = rk_req & key_valid, combinational. s_addr = rk_index. rk_data = s_rdata.
  - rk_index >= T while granted: rk_data undefined. Flagging this is a bench assertion, not RTL.
- INIT:
  - Each cycle writes S[k] = P + k*Q (mod 2^W), using a running accumulator.
  - k runs 0..T-1, one word per cycle, T cycles total.
  - After k=T-1, go to MIX_A with i=j=0 and A=B=0.
- MIX_A (1 cycle): s_addr=i. tmp = rotl(s_rdata + A + B, 3). Write S[i]=tmp. Register A=tmp.
- MIX_B (1 cycle):
  - l_addr=j. tmp = rotl(l_rdata + A + B, (A+B) mod W). Write L[j]=tmp. Register B=tmp.
  - Advance i = (i+1) mod T and j = (j+1) mod C, with independent wrap.
  - Increment the iteration counter.
  - If counter reaches N = 3*max(T,C), go to FIN; else go to MIX_A.
- FIN (1 cycle): done=1, key_valid=1, busy=0. Next state is IDLE.
- Timing:
  - busy=1 from the cycle after start is sampled through the last MIX_B: T + 2N cycles (154 at defaults).
  - done and key_valid rise on the same edge that busy falls.
- While busy: rk_gnt=0 regardless of rk_req. The core must hold its request. start is ignored.
- Arithmetic: all adds are modulo 2^W. Rotation is left rotation; amount 0 leaves the value unchanged.
- start asserted in FIN: ignored. It is accepted only if still high in IDLE.
- start asserted in IDLE simultaneously with rk_req:
  - The start takes effect (state -> INIT).
  - The rk_req in that cycle is still granted, because IDLE logic is combinational on the current state.
  - key_valid clears on the next edge.
- Host must not write L while busy. The controller owns the l port whenever busy=1.

Test Plan:
- Reset, L=0, pulse start -> S[0]=B7E15163, S[1]=5618CB1C, S[21]=P+21Q written during INIT.
- Continue the run:
  - First MIX_A writes S[0]=BF0A8B1D.
  - First MIX_B: rotation by 29 writes L[0]=B7E15163.
  - busy high exactly 154 cycles; one done pulse.
- Full expansion with L = {FFFFDDDD, AAAAFFFF, FFFFBBBB, CCCCFFFF} -> S[0..21] match the software RC5 model bit-exact; key_valid=1.
- rk_req with rk_index=5 held during busy -> rk_gnt=0 throughout. In the cycle after FIN: rk_gnt=1, rk_data=S[5].
- Assert reset at cycle 60 of expansion -> next cycle busy=0, key_valid=0, no further s_we/l_we. A new start gives a correct full expansion.
- start pulses repeated during busy and in FIN -> no restart; exactly one done per accepted start; cycle count unchanged (154).
